// File: rtl/prover_early_round_ctrl.sv
// prover_early_round_ctrl
// Sequences the early (copy-variable) sumcheck rounds. It issues one restart
// invocation of the V datapath and then nCopyBits binding invocations. Each
// round's coefficients are offered to the transcript side, and the returned
// challenge becomes the tau of the next invocation.

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module prover_early_round_ctrl #(
    parameter int nCopyBits  = 3,
    parameter int nRoundBits = $clog2(nCopyBits + 1)
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      start,
    input  logic                      abort,
    output logic                      v_en,
    output logic                      v_restart,
    output logic [`F_NBITS-1:0]       v_tau,
    output logic [`F_NBITS-1:0]       v_m_tau_p1,
    input  logic                      v_ready_pulse,
    input  logic [4*`F_NBITS-1:0]     v_c,
    output logic [4*`F_NBITS-1:0]     coef_out,
    output logic                      coef_valid,
    input  logic                      coef_ready,
    output logic [nRoundBits-1:0]     round_idx,
    output logic                      chal_ready,
    input  logic                      chal_valid,
    input  logic [`F_NBITS-1:0]       chal_in,
    output logic                      busy,
    output logic                      done
);

    localparam int W = `F_NBITS;
    localparam logic [W-1:0] FQ = `F_Q;
    localparam logic [nRoundBits-1:0] LAST_ROUND = nRoundBits'(nCopyBits);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT,
        CHAL,
        DRAIN
    } state_t;

    state_t                state, state_d;
    logic [nRoundBits-1:0] round, round_d;
    logic [W-1:0]          tau_d, mtp1_d;
    logic [4*W-1:0]        coef_d;
    logic                  done_d;
    logic [W:0]            mtp1_wide;

    // (1 - tau) mod q, formed one bit wider so q + 1 - tau cannot overflow
    always_comb begin
        if (chal_in <= W'(1))
            mtp1_wide = (W+1)'(1) - {1'b0, chal_in};
        else
            mtp1_wide = {1'b0, FQ} + (W+1)'(1) - {1'b0, chal_in};
    end

    // Next-state and next-register values; abort is checked first so it wins
    always_comb begin
        state_d = state;
        round_d = round;
        tau_d   = v_tau;
        mtp1_d  = v_m_tau_p1;
        coef_d  = coef_out;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    round_d = '0;
                    tau_d   = '0;
                    mtp1_d  = W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) state_d = DRAIN;
                else       state_d = WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_d = DRAIN;
                end else if (v_ready_pulse) begin
                    if (round == LAST_ROUND) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        coef_d  = v_c;
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (abort)           state_d = IDLE;
                else if (coef_ready) state_d = CHAL;
            end
            CHAL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (chal_valid) begin
                    tau_d   = chal_in;
                    mtp1_d  = mtp1_wide[W-1:0];
                    round_d = round + nRoundBits'(1);
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (v_ready_pulse) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and Moore output registers, all decoded from the next state
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            round      <= '0;
            v_tau      <= '0;
            v_m_tau_p1 <= W'(1);
            coef_out   <= '0;
            v_en       <= 1'b0;
            v_restart  <= 1'b0;
            coef_valid <= 1'b0;
            chal_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            round      <= round_d;
            v_tau      <= tau_d;
            v_m_tau_p1 <= mtp1_d;
            coef_out   <= coef_d;
            v_en       <= (state_d == ISSUE);
            v_restart  <= (state_d == ISSUE) && (round_d == '0);
            coef_valid <= (state_d == PRESENT);
            chal_ready <= (state_d == CHAL);
            busy       <= (state_d != IDLE);
            done       <= done_d;
        end
    end

    assign round_idx = round;

endmodule

// File: tb/tb_prover_early_round_ctrl.sv
// Directed testbench for prover_early_round_ctrl with nCopyBits = 3.

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_prover_early_round_ctrl;

    localparam int W = `F_NBITS;
    localparam logic [W-1:0] FQ = `F_Q;

    logic           clk = 1'b0;
    logic           rstb = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           v_en;
    logic           v_restart;
    logic [W-1:0]   v_tau;
    logic [W-1:0]   v_m_tau_p1;
    logic           v_ready_pulse = 1'b0;
    logic [4*W-1:0] v_c = '0;
    logic [4*W-1:0] coef_out;
    logic           coef_valid;
    logic           coef_ready = 1'b0;
    logic [1:0]     round_idx;
    logic           chal_ready;
    logic           chal_valid = 1'b0;
    logic [W-1:0]   chal_in = '0;
    logic           busy;
    logic           done;

    int vectors = 0;
    int miscompares = 0;
    int en_count = 0;
    int xfer_count = 0;
    int done_count = 0;
    int en_violations = 0;
    logic prev_en = 1'b0;

    prover_early_round_ctrl #(.nCopyBits(3)) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort),
        .v_en(v_en), .v_restart(v_restart), .v_tau(v_tau), .v_m_tau_p1(v_m_tau_p1),
        .v_ready_pulse(v_ready_pulse), .v_c(v_c),
        .coef_out(coef_out), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .round_idx(round_idx), .chal_ready(chal_ready), .chal_valid(chal_valid),
        .chal_in(chal_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (v_en && prev_en) en_violations++;
        prev_en = v_en;
        if (v_en) en_count++;
        if (coef_valid && coef_ready) xfer_count++;
        if (done) done_count++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic dp_return(input logic [4*W-1:0] c);
        repeat (3) tick();
        v_ready_pulse = 1'b1;
        v_c = c;
        tick();
        v_ready_pulse = 1'b0;
    endtask

    task automatic coef_handshake();
        coef_ready = 1'b1;
        tick();
        coef_ready = 1'b0;
    endtask

    task automatic give_chal(input logic [W-1:0] x);
        chal_valid = 1'b1;
        chal_in = x;
        tick();
        chal_valid = 1'b0;
    endtask

    function automatic logic [4*W-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    initial begin
        int en_base, xfer_base, done_base;
        logic [4*W-1:0] held;

        // Reset values
        #12;
        check("rst_v_en", v_en, 0);
        check("rst_v_restart", v_restart, 0);
        check("rst_v_tau", v_tau, 0);
        check("rst_m_tau_p1", v_m_tau_p1, 1);
        check("rst_coef_out", coef_out, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_chal_ready", chal_ready, 0);
        check("rst_round", round_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rstb = 1'b1;
        tick();

        // Full run with backpressure in the first round
        en_base = en_count; xfer_base = xfer_count; done_base = done_count;
        do_start();
        check("r0_v_en", v_en, 1);
        check("r0_restart", v_restart, 1);
        check("r0_busy", busy, 1);
        check("r0_tau", v_tau, 0);
        check("r0_mtp1", v_m_tau_p1, 1);
        tick();
        check("r0_en_single", v_en, 0);
        dp_return(pack4(4, 3, 2, 1));
        check("r0_coef_valid", coef_valid, 1);
        check("r0_coef_out", coef_out, pack4(4, 3, 2, 1));
        check("r0_round", round_idx, 0);
        held = coef_out;
        v_c = pack4(9, 9, 9, 9);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin chal_valid = 1'b1; chal_in = W'(77); end
            if (i == 4) begin chal_valid = 1'b0; start = 1'b1; end
            if (i == 5) start = 1'b0;
            tick();
            check("bp_coef_valid", coef_valid, 1);
            check("bp_coef_stable", coef_out, held);
            check("bp_no_en", v_en, 0);
        end
        check("bp_chal_ready", chal_ready, 0);
        check("bp_tau", v_tau, 0);
        coef_handshake();
        check("r0_chal_ready", chal_ready, 1);
        check("r0_coef_dropped", coef_valid, 0);
        give_chal(W'(5));
        check("r1_v_en", v_en, 1);
        check("r1_restart", v_restart, 0);
        check("r1_tau", v_tau, 5);
        check("r1_mtp1", v_m_tau_p1, FQ - W'(4));
        check("r1_round", round_idx, 1);
        dp_return(pack4(8, 7, 6, 5));
        check("r1_coef_out", coef_out, pack4(8, 7, 6, 5));
        check("r1_tau_hold", v_tau, 5);
        coef_handshake();
        give_chal(W'(7));
        check("r2_tau", v_tau, 7);
        check("r2_mtp1", v_m_tau_p1, FQ - W'(6));
        check("r2_restart", v_restart, 0);
        dp_return(pack4(12, 11, 10, 9));
        coef_handshake();
        give_chal(W'(9));
        check("r3_v_en", v_en, 1);
        check("r3_tau", v_tau, 9);
        check("r3_mtp1", v_m_tau_p1, FQ - W'(8));
        check("r3_round", round_idx, 3);
        dp_return(pack4(0, 0, 0, 0));
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_no_coef", coef_valid, 0);
        tick();
        check("fin_done_pulse", done, 0);
        check("run_en_count", en_count - en_base, 4);
        check("run_xfer_count", xfer_count - xfer_base, 3);
        check("run_done_count", done_count - done_base, 1);

        // m_tau_p1 edge values
        do_start();
        dp_return(pack4(1, 1, 1, 1));
        coef_handshake();
        give_chal(W'(0));
        check("edge0_mtp1", v_m_tau_p1, 1);
        dp_return(pack4(1, 1, 1, 1));
        coef_handshake();
        give_chal(W'(1));
        check("edge1_mtp1", v_m_tau_p1, 0);
        dp_return(pack4(1, 1, 1, 1));
        coef_handshake();
        give_chal(FQ - W'(1));
        check("edgeq_tau", v_tau, FQ - W'(1));
        check("edgeq_mtp1", v_m_tau_p1, 2);
        dp_return(pack4(0, 0, 0, 0));
        check("edge_done", done, 1);
        tick();

        // Abort in WAIT drains the outstanding datapath pulse
        done_base = done_count;
        do_start();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abw_busy", busy, 1);
        repeat (4) tick();
        check("abw_still_busy", busy, 1);
        check("abw_no_en", v_en, 0);
        v_ready_pulse = 1'b1;
        tick();
        v_ready_pulse = 1'b0;
        check("abw_idle", busy, 0);
        check("abw_no_coef", coef_valid, 0);
        tick();
        check("abw_no_done", done_count - done_base, 0);

        // Abort in CHAL returns to IDLE at once
        do_start();
        dp_return(pack4(2, 2, 2, 2));
        coef_handshake();
        check("abc_chal_ready", chal_ready, 1);
        abort = 1'b1;
        chal_valid = 1'b1;
        chal_in = W'(3);
        tick();
        abort = 1'b0;
        chal_valid = 1'b0;
        check("abc_chal_dropped", chal_ready, 0);
        check("abc_busy", busy, 0);
        check("abc_no_en", v_en, 0);
        check("abc_tau_kept", v_tau, 0);

        // Reset during CHAL
        do_start();
        dp_return(pack4(3, 3, 3, 3));
        coef_handshake();
        give_chal(W'(5));
        dp_return(pack4(3, 3, 3, 3));
        coef_handshake();
        check("rm_round_before", round_idx, 1);
        rstb = 1'b0;
        #2;
        check("rm_tau", v_tau, 0);
        check("rm_mtp1", v_m_tau_p1, 1);
        check("rm_round", round_idx, 0);
        check("rm_chal_ready", chal_ready, 0);
        check("rm_busy", busy, 0);
        check("rm_coef_out", coef_out, 0);
        @(negedge clk);
        rstb = 1'b1;
        tick();
        do_start();
        check("rm_restart", v_restart, 1);
        check("rm_en", v_en, 1);
        check("rm_round0", round_idx, 0);
        repeat (3) tick();

        check("en_never_back_to_back", en_violations, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prover_early_round_ctrl.md
# prover_early_round_ctrl

Round sequencer for the early (copy-variable) sumcheck rounds of the prover. It drives the en/restart/tau/m_tau_p1 inputs of the early-round V-computation datapath and issues one restart invocation followed by nCopyBits binding invocations. Each round's four coefficients are captured and offered to the transcript/verifier side over a valid/ready handshake. The controller then accepts that side's challenge and uses it as the tau for the next invocation.

## Interface
- nCopyBits, 3: number of early rounds; must be ≥ 2.
- nRoundBits, $clog2(nCopyBits+1): round counter width; do not override.
- clk  in  1  clock.
- rstb  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE.
- abort  in  1  one-cycle pulse; terminates the run without done.
- v_en  out  1  one-cycle enable pulse to the datapath.
- v_restart  out  1  restart qualifier, valid while v_en is high.
- v_tau  out  F_NBITS  tau to the datapath.
- v_m_tau_p1  out  F_NBITS  (1 − tau) mod `F_Q.
- v_ready_pulse  in  1  datapath completion pulse.
- v_c  in  F_NBITS×4  datapath coefficients c[3:0].
- coef_out  out  F_NBITS×4  captured coefficients.
- coef_valid  out  1  coef_out is valid.
- coef_ready  in  1  consumer accepts coef_out.
- round_idx  out  nRoundBits  current round index, 0..nCopyBits.
- chal_ready  out  1  controller is waiting for a challenge.
- chal_valid  in  1  chal_in is valid.
- chal_in  in  F_NBITS  challenge, < `F_Q.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run completes.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, CHAL, DRAIN.
- **IDLE**
  - On start: round ← 0, v_tau ← 0, v_m_tau_p1 ← 1; go to ISSUE.
- **ISSUE** (exactly one cycle)
  - v_en = 1 and v_restart = (round == 0); go to WAIT.
- **WAIT**
  - On v_ready_pulse with round < nCopyBits: coef_out ← v_c; go to PRESENT.
  - On v_ready_pulse with round == nCopyBits: pulse done; go to IDLE. This final binding invocation produces no coefficients.
- **PRESENT**
  - coef_valid = 1. When coef_valid & coef_ready, go to CHAL.
- **CHAL**
  - chal_ready = 1. On chal_valid:
    - v_tau ← chal_in;
    - v_m_tau_p1 ← (chal_in ≤ 1) ? 1 − chal_in : `F_Q + 1 − chal_in, computed at F_NBITS+1 bits, then truncated;
    - round ← round + 1; go to ISSUE.
- **DRAIN**
  - Wait for v_ready_pulse, discard v_c, then go to IDLE. done is not pulsed.
- Per full run:
  - nCopyBits+1 v_en pulses;
  - nCopyBits coefficient transfers;
  - nCopyBits challenges;
  - one done pulse.
- abort handling:
  - In ISSUE or WAIT: go to DRAIN. The datapath cannot be cancelled, so its pulse must be absorbed.
  - In PRESENT or CHAL: go to IDLE immediately and drop coef_valid/chal_ready.
  - In IDLE or DRAIN: ignored.
- Pulses ignored outside their states:
  - start when not IDLE;
  - v_ready_pulse outside WAIT and DRAIN;
  - chal_valid outside CHAL.
- Simultaneous events:
  - abort wins over v_ready_pulse, coef_ready and chal_valid in the same cycle.
  - start and abort together in IDLE: start wins.

## Timing
- All outputs are registered Moore outputs.
- Reset values:
  - v_en = 0, v_restart = 0, v_tau = 0, v_m_tau_p1 = 1;
  - coef_out = 0, coef_valid = 0, chal_ready = 0;
  - round_idx = 0, busy = 0, done = 0.
- Latencies:
  - start sampled at edge k → v_en high in cycle k+1.
  - v_ready_pulse at edge k → coef_valid high from cycle k+1.
  - coef handshake at edge k → chal_ready high from cycle k+1.
  - chal_valid at edge k → new v_tau/v_m_tau_p1 and v_en high in cycle k+1.
  - Final v_ready_pulse at edge k → done high in cycle k+1 and busy low in cycle k+1.
- Hold requirements:
  - v_tau and v_m_tau_p1 stay constant from ISSUE until the next capture in CHAL. The datapath samples them over many cycles.
  - coef_out is stable while coef_valid is high.
- v_en is never high in two consecutive cycles. The datapath edge-detects en.
- round_idx follows the round register. busy is high from the cycle after start until the cycle done is high.

## Test plan
- **First round:** nCopyBits=3; start; datapath model returns c={1,2,3,4} → v_en/v_restart=1 one cycle after start; coef_out={1,2,3,4}; round_idx=0.
- **Full run:** challenges 5, 7, 9 →
  - v_tau sequence 0, 5, 7, 9;
  - v_restart only on the first v_en;
  - v_m_tau_p1 = `F_Q−4, `F_Q−6, `F_Q−8;
  - exactly 4 v_en pulses and 3 coef transfers;
  - done one cycle after the 4th v_ready_pulse.
- **m_tau_p1 edges:** chal_in 0→1, 1→0, `F_Q−1→2.
- **Backpressure:** coef_ready low for 10 cycles → coef_out/coef_valid stable, no v_en, chal_valid during PRESENT ignored; start mid-run ignored.
- **Abort:**
  - abort in WAIT → busy stays high until v_ready_pulse, then IDLE with no done;
  - abort in CHAL → IDLE next cycle, chal_ready low.
- **Reset mid-run:** rstb low during CHAL → all outputs at reset values; next start issues v_restart=1 with round_idx=0.
